mux_gate_sequencer: RTL and testbench

//  Clocked driver stage directly upstream of the 2:1 RC mux/gate cell. Its outputs go through

---
 rtl/mux_gate_sequencer_if.sv | 44 ++++
 rtl/mux_gate_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mux_gate_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_gate_sequencer_if.sv
// ---------------------------------------------------------------------------
// mux_gate_sequencer_if
//   Bundles the event handshake, the cell drive/sense signals and the status
//   outputs of mux_gate_sequencer.
//
//   Handshake: an event {ev_sel, ev_d0} transfers on a rising clk edge where
//   ev_valid and ev_ready are both 1. ev_valid must be held, with stable data,
//   until that edge. ev_ready depends only on internal state, never on ev_valid.
//
//   Modports
//     slave  : the sequencer (consumes events, drives the cell and status)
//     master : the environment (offers events, returns the cell output y_in)
//   Signals
//     ev_valid/ev_ready/ev_d0/ev_sel   event handshake and payload
//     sel_out/d0_out                   registered drive to the SEL/D0 converters
//     y_in                             cell output Y, synchronous to clk
//     busy/err/err_cnt                 status
//     dbg_state                        current FSM state encoding
// ---------------------------------------------------------------------------
interface mux_gate_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_d0;
    logic             ev_sel;
    logic             sel_out;
    logic             d0_out;
    logic             y_in;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       dbg_state;

    modport slave (
        input  ev_valid, ev_d0, ev_sel, y_in,
        output ev_ready, sel_out, d0_out, busy, err, err_cnt, dbg_state
    );

    modport master (
        output ev_valid, ev_d0, ev_sel, y_in,
        input  ev_ready, sel_out, d0_out, busy, err, err_cnt, dbg_state
    );
endinterface

// File: rtl/mux_gate_sequencer.sv
// ---------------------------------------------------------------------------
// mux_gate_sequencer
//   Driver stage in front of a 2:1 RC mux/gate cell (Y = D0 & ~SEL).
//   Spike events are queued in a small FIFO and each is replayed as
//   SEL-setup (SETTLE_CYC), D0 pulse (PULSE_CYC), then gap (GAP_CYC).
//   Queued events chain back-to-back without an IDLE cycle.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active-high
//     bus  : mux_gate_sequencer_if.slave (handshake, cell drive, status)
//
//   Optional feature: define MUX_SEQ_CHECK_EN to compare y_in against the
//   expected cell output on the last PULSE cycle of every event; mismatches
//   set a sticky err flag and bump a saturating err_cnt. Without the macro,
//   err/err_cnt are tied to 0 and y_in is ignored.
// ---------------------------------------------------------------------------
module mux_gate_sequencer #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int PULSE_CYC  = 4,
    parameter int GAP_CYC    = 1,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_gate_sequencer_if.slave   bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int MAX_SP = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int MAX_P  = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
    localparam int CW     = $clog2(MAX_P) + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, PULSE, GAP} state_t;

    // ---------------- FIFO ----------------
    logic [1:0]    mem_q [DEPTH];   // {sel, d0}
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] wr_nxt, rd_nxt;
    logic          full_q, empty_q;
    logic          push, pop;

    assign wr_nxt = wr_ptr_q + 1'b1;
    assign rd_nxt = rd_ptr_q + 1'b1;
    // Full blocks a push even in a cycle that also pops.
    assign push   = bus.ev_valid & ~full_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.ev_sel, bus.ev_d0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_nxt;
            if (pop)  rd_ptr_q <= rd_nxt;
            // Simultaneous push and pop leave the occupancy, hence the flags, unchanged.
            if (push && !pop) begin
                empty_q <= 1'b0;
                full_q  <= (wr_nxt == rd_ptr_q);
            end else if (pop && !push) begin
                full_q  <= 1'b0;
                empty_q <= (rd_nxt == wr_ptr_q);
            end
        end
    end

    // ---------------- FSM ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cur_sel_q, cur_sel_d;
    logic          cur_d0_q, cur_d0_d;
    logic          sel_q, sel_d;
    logic          d0_q, d0_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_sel_q <= 1'b1;
            cur_d0_q  <= 1'b0;
            sel_q     <= 1'b1;
            d0_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            cur_d0_q  <= cur_d0_d;
            sel_q     <= sel_d;
            d0_q      <= d0_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        cur_d0_d  = cur_d0_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop       = 1'b1;
                    {cur_sel_d, cur_d0_d} = mem_q[rd_ptr_q];
                    state_d   = SETTLE;
                    cnt_d     = CW'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CW'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CW'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (!empty_q) begin
                        // Chain straight into the next event; SEL goes directly to the new value.
                        pop       = 1'b1;
                        {cur_sel_d, cur_d0_d} = mem_q[rd_ptr_q];
                        state_d   = SETTLE;
                        cnt_d     = CW'(SETTLE_CYC - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        sel_d = (state_d == IDLE) ? 1'b1 : cur_sel_d;
        d0_d  = (state_d == PULSE) ? cur_d0_d : 1'b0;
    end

    assign bus.sel_out   = sel_q;
    assign bus.d0_out    = d0_q;
    assign bus.ev_ready  = ~full_q;
    assign bus.busy      = (state_q != IDLE) | ~empty_q;
    assign bus.dbg_state = state_q;

    // ---------------- optional output check ----------------
`ifdef MUX_SEQ_CHECK_EN
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             chk_fire;

    assign chk_fire = (state_q == PULSE) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (chk_fire && (bus.y_in != (cur_d0_q & ~cur_sel_q))) begin
            err_q <= 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err     = 1'b0;
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_gate_sequencer
//   Directed bench for mux_gate_sequencer with default parameters
//   (SETTLE 2, PULSE 4, GAP 1 -> 7-cycle event period). Inputs change and
//   outputs are sampled on the falling edge; "after Ek" means the falling edge
//   following rising edge k, where E0 is the first accept of a sequence.
// ---------------------------------------------------------------------------
module tb_mux_gate_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_y = 1'b0;

    int errors = 0;
    int checks = 0;

    mux_gate_sequencer_if #(.CNT_W(8)) bus ();

    mux_gate_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // RC cell model: Y = D0 & ~SEL, optionally stuck high.
    assign bus.y_in = force_y ? 1'b1 : (bus.d0_out & ~bus.sel_out);

    always #5 clk = ~clk;

    // Sequence description shared with run_seq.
    logic seq_sel [8];
    logic seq_d0 [8];
    int   seq_earliest [8];
    int   acc_edge [8];
    logic ready_hist [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ev_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", bus.sel_out, 1);
        check("rst_d0", bus.d0_out, 0);
        check("rst_ready", bus.ev_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_errcnt", bus.err_cnt, 0);
        rst = 1'b0;
    endtask

    // Offers n events in order (each no earlier than seq_earliest), holding
    // ev_valid until accepted, and checks sel/d0/busy each cycle against a
    // back-to-back replay timeline whose first SETTLE begins after E1.
    task automatic run_seq(input int n, input int ncyc);
        int   idx;
        logic rdy_prev;
        int   k, i, p;
        logic exp_sel, exp_d0, exp_busy;
        idx = 0;
        rdy_prev = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            ready_hist[c] = bus.ev_ready;
            if (c >= 1) begin
                k = c - 1;
                if (k >= 1 && k < 1 + 7 * n) begin
                    i = (k - 1) / 7;
                    p = (k - 1) % 7;
                    exp_sel = seq_sel[i];
                    exp_d0  = (p >= 2 && p <= 5) ? seq_d0[i] : 1'b0;
                end else begin
                    exp_sel = 1'b1;
                    exp_d0  = 1'b0;
                end
                exp_busy = (k < 1 + 7 * n);
                check("seq_sel", bus.sel_out, exp_sel);
                check("seq_d0", bus.d0_out, exp_d0);
                check("seq_busy", bus.busy, exp_busy);
                if (bus.ev_valid && rdy_prev) idx++;
            end
            if (idx < n && c >= seq_earliest[idx]) begin
                bus.ev_valid = 1'b1;
                bus.ev_sel   = seq_sel[idx];
                bus.ev_d0    = seq_d0[idx];
            end else begin
                bus.ev_valid = 1'b0;
            end
            rdy_prev = bus.ev_ready;
            if (bus.ev_valid && bus.ev_ready) acc_edge[idx] = c;
        end
        bus.ev_valid = 1'b0;
        check("seq_all_accepted", idx, n);
    endtask

    initial begin
        bus.ev_valid = 1'b0;
        bus.ev_sel   = 1'b0;
        bus.ev_d0    = 1'b0;

        // Single event sel=0, d0=1: sel_out 0 after E1, d0 high after E3..E6, idle after E8.
        do_reset();
        seq_sel[0] = 1'b0; seq_d0[0] = 1'b1; seq_earliest[0] = 0;
        run_seq(1, 12);
        check("t2_err", bus.err, 0);

        // Six events back-to-back; the 6th waits for the pop at E8 and lands at E9.
        do_reset();
        seq_sel[0] = 1'b0; seq_d0[0] = 1'b1;
        seq_sel[1] = 1'b1; seq_d0[1] = 1'b1;
        seq_sel[2] = 1'b0; seq_d0[2] = 1'b0;
        seq_sel[3] = 1'b0; seq_d0[3] = 1'b1;
        seq_sel[4] = 1'b1; seq_d0[4] = 1'b0;
        seq_sel[5] = 1'b0; seq_d0[5] = 1'b1;
        for (int j = 0; j < 6; j++) seq_earliest[j] = 0;
        run_seq(6, 48);
        check("t3_acc4", acc_edge[4], 4);
        check("t3_ready_full_e4", ready_hist[5], 0);
        check("t3_ready_full_e8", ready_hist[8], 0);
        check("t3_ready_e8", ready_hist[9], 1);
        check("t3_acc5", acc_edge[5], 9);

        // Push at GAP exit together with the pop of the one queued entry.
        do_reset();
        seq_sel[0] = 1'b0; seq_d0[0] = 1'b1; seq_earliest[0] = 0;
        seq_sel[1] = 1'b1; seq_d0[1] = 1'b1; seq_earliest[1] = 1;
        seq_sel[2] = 1'b0; seq_d0[2] = 1'b1; seq_earliest[2] = 8;
        run_seq(3, 26);
        check("t6_acc1", acc_edge[1], 1);
        check("t6_acc2", acc_edge[2], 8);
        check("t6_ready_e8", ready_hist[9], 1);

        // Async reset on the 2nd PULSE cycle with 3 events queued.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                bus.ev_valid = 1'b1;
                bus.ev_sel   = 1'b0;
                bus.ev_d0    = 1'b1;
            end else begin
                bus.ev_valid = 1'b0;
            end
        end
        check("t5_pulse_d0", bus.d0_out, 1);
        check("t5_pulse_sel", bus.sel_out, 0);
        #2 rst = 1'b1;
        #1;
        check("t1_async_sel", bus.sel_out, 1);
        check("t1_async_d0", bus.d0_out, 0);
        check("t1_async_ready", bus.ev_ready, 1);
        check("t1_async_busy", bus.busy, 0);
        check("t1_async_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t5_idle_sel", bus.sel_out, 1);
            check("t5_idle_d0", bus.d0_out, 0);
            check("t5_idle_busy", bus.busy, 0);
        end

`ifdef MUX_SEQ_CHECK_EN
        // sel=1, d0=1 with y stuck high: mismatch on every event, counter saturates.
        do_reset();
        force_y = 1'b1;
        for (int r = 0; r < 300; r++) begin
            @(negedge clk);
            bus.ev_valid = 1'b1;
            bus.ev_sel   = 1'b1;
            bus.ev_d0    = 1'b1;
            @(negedge clk);
            bus.ev_valid = 1'b0;
            repeat (6) @(negedge clk);
            if (r == 0) begin
                check("t4_err_before", bus.err, 0);
                check("t4_cnt_before", bus.err_cnt, 0);
            end
            @(negedge clk);
            if (r == 0) begin
                check("t4_err", bus.err, 1);
                check("t4_cnt1", bus.err_cnt, 1);
            end
            @(negedge clk);
        end
        check("t4_err_sticky", bus.err, 1);
        check("t4_cnt_sat", bus.err_cnt, 255);
        force_y = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
